fill_rect: RTL and testbench

FILL_RECT -- requirements
Module: fill_rect

---
 rtl/fill_pkg.sv | 21 ++
 rtl/fill_scan_ctr.sv | 58 +++++
 rtl/fill_rect.sv | 170 +++++++++++++++++
 tb/tb_fill_rect.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fill_pkg.sv
// Shared types and default screen geometry for the rectangle filler.
package fill_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_SOLID,
        MODE_COLSTRIPE,
        MODE_ROWSTRIPE,
        MODE_CHECKER
    } mode_t;

endpackage

// File: rtl/fill_scan_ctr.sv
// Column-major x/y scan counter: y runs inner, x outer, with a last-pixel flag.
module fill_scan_ctr #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_en,
    input  logic [XW-1:0] i_x0,
    input  logic [XW-1:0] i_x1,
    input  logic [YW-1:0] i_y0,
    input  logic [YW-1:0] i_y1,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [XW-1:0] o_nx,
    output logic [YW-1:0] o_ny,
    output logic          o_last
);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_col_end;

    assign w_col_end = (r_y == i_y1);
    assign o_last    = w_col_end && (r_x == i_x1);
    assign o_x       = r_x;
    assign o_y       = r_y;

    // Ends are detected by equality, never by an incremented value, so a
    // bound at the all-ones coordinate cannot wrap the scan.
    always_comb begin
        o_nx = r_x;
        o_ny = r_y;
        if (i_load) begin
            o_nx = i_x0;
            o_ny = i_y0;
        end else if (i_en) begin
            if (w_col_end) begin
                o_nx = r_x + XW'(1);
                o_ny = i_y0;
            end else begin
                o_ny = r_y + YW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= o_nx;
            r_y <= o_ny;
        end
    end

endmodule

// File: rtl/fill_rect.sv
// Rectangle fill engine: latches a clamped rectangle and streams its pixels
// column-major to a ready-gated plot interface, colouring them by fill mode.
module fill_rect
    import fill_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour,
    input  logic [1:0]    mode,
    input  logic          plot_ready,
    output logic          busy,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    localparam logic [XW-1:0] XMAX = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(SCREEN_H - 1);

    state_t        r_state;
    logic          r_ld_phase;
    logic          r_busy;
    logic          r_done;
    logic          r_plot;
    logic [CW-1:0] r_vga_colour;
    logic [XW-1:0] r_x0;
    logic [XW-1:0] r_x1;
    logic [YW-1:0] r_y0;
    logic [YW-1:0] r_y1;
    logic [CW-1:0] r_colour;
    mode_t         r_mode;

    logic [XW-1:0] w_x1c;
    logic [YW-1:0] w_y1c;
    logic          w_empty;
    logic          w_latch;
    logic          w_load;
    logic          w_en;
    logic [XW-1:0] w_x;
    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_y;
    logic [YW-1:0] w_ny;
    logic          w_last;

    function automatic logic [CW-1:0] pixel_colour(
        input mode_t         m,
        input logic [CW-1:0] c,
        input logic [XW-1:0] x,
        input logic [YW-1:0] y
    );
        case (m)
            MODE_SOLID:     return c;
            MODE_COLSTRIPE: return c + x[CW-1:0];
            MODE_ROWSTRIPE: return c + y[CW-1:0];
            default:        return (x[0] ^ y[0]) ? ~c : c;
        endcase
    endfunction

    // An off-screen x0/y0 always exceeds the clamped far bound, so one test covers both.
    assign w_x1c   = (x1 > XMAX) ? XMAX : x1;
    assign w_y1c   = (y1 > YMAX) ? YMAX : y1;
    assign w_empty = (x0 > w_x1c) || (y0 > w_y1c);

    assign w_latch = (r_state == ST_LOAD) && !r_ld_phase;
    assign w_load  = (r_state == ST_LOAD) && r_ld_phase;
    assign w_en    = (r_state == ST_FILL) && plot_ready && !w_last;

    fill_scan_ctr #(
        .XW(XW),
        .YW(YW)
    ) u_scan (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_en   (w_en),
        .i_x0   (r_x0),
        .i_x1   (r_x1),
        .i_y0   (r_y0),
        .i_y1   (r_y1),
        .o_x    (w_x),
        .o_y    (w_y),
        .o_nx   (w_nx),
        .o_ny   (w_ny),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_x0     <= x0;
            r_x1     <= w_x1c;
            r_y0     <= y0;
            r_y1     <= w_y1c;
            r_colour <= colour;
            r_mode   <= mode_t'(mode);
        end
    end

    // LOAD spends a second cycle loading the scan counter from the latched
    // bounds, so the first pixel is registered two cycles after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ld_phase   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_plot       <= 1'b0;
            r_vga_colour <= '0;
        end else begin
            r_vga_colour <= pixel_colour(r_mode, r_colour, w_nx, w_ny);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_ld_phase <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!r_ld_phase) begin
                        if (w_empty) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ld_phase <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_FILL;
                        r_plot  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (plot_ready && w_last) begin
                        r_state <= ST_DONE;
                        r_plot  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (!start) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign vga_plot   = r_plot;
    assign vga_x      = w_x;
    assign vga_y      = w_y;
    assign vga_colour = r_vga_colour;

endmodule

// File: tb/tb_fill_rect.sv
// Bench for fill_rect: pixel-list model with a per-cycle compare process,
// directed rectangles, stalls, clamping, empty requests and reset abort.
module tb_fill_rect;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [CW-1:0] colour;
    logic [1:0]    mode;
    logic          plot_ready;
    logic          busy;
    logic          done;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    fill_rect #(
        .SCREEN_W(W),
        .SCREEN_H(H),
        .XW(XW),
        .YW(YW),
        .CW(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .colour     (colour),
        .mode       (mode),
        .plot_ready (plot_ready),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    pix_t seen_q[$];
    int   hold_len[$];
    int   checks = 0;
    int   errors = 0;
    int   acc = 0;
    int   hold_cur = 0;

    function automatic int model_colour(input int c, input int m, input int x, input int y);
        case (m)
            0:       return c;
            1:       return (c + x) % 8;
            2:       return (c + y) % 8;
            default: return ((x + y) % 2 == 0) ? c : 7 - c;
        endcase
    endfunction

    task automatic build_model(input int ax0, input int ax1, input int ay0, input int ay1,
                               input int c, input int m);
        pix_t p;
        exp_q.delete();
        for (int x = ax0; x <= ax1 && x < W; x++)
            for (int y = ay0; y <= ay1 && y < H; y++) begin
                p.x = x;
                p.y = y;
                p.c = model_colour(c, m, x, y);
                exp_q.push_back(p);
            end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Compare process: every plotted cycle must show the model's next pixel.
    always @(negedge clk) begin
        pix_t p;
        if (!rst && vga_plot) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_plot at (%0d,%0d) required no plot", vga_x, vga_y);
            end else begin
                if (int'(vga_x) != exp_q[0].x || int'(vga_y) != exp_q[0].y ||
                    int'(vga_colour) != exp_q[0].c) begin
                    errors++;
                    $display("FAIL pixel actual (%0d,%0d) c=%0d required (%0d,%0d) c=%0d",
                             vga_x, vga_y, vga_colour, exp_q[0].x, exp_q[0].y, exp_q[0].c);
                end
                hold_cur++;
                if (plot_ready) begin
                    p.x = int'(vga_x);
                    p.y = int'(vga_y);
                    p.c = int'(vga_colour);
                    seen_q.push_back(p);
                    hold_len.push_back(hold_cur);
                    hold_cur = 0;
                    void'(exp_q.pop_front());
                    acc++;
                end
            end
        end
    end

    task automatic do_op(input string name, input int ax0, input int ax1, input int ay0,
                         input int ay1, input int c, input int m, input int stall_idx,
                         input int stall_len, input int keep_start, input int exp_lat);
        int n;
        int k;
        int stalled;
        bit got;
        build_model(ax0, ax1, ay0, ay1, c, m);
        n = exp_q.size();
        seen_q.delete();
        hold_len.delete();
        acc = 0;
        hold_cur = 0;
        stalled = 0;
        @(posedge clk);
        #1;
        x0 = ax0[XW-1:0];
        x1 = ax1[XW-1:0];
        y0 = ay0[YW-1:0];
        y1 = ay1[YW-1:0];
        colour = c[CW-1:0];
        mode = m[1:0];
        start = 1'b1;
        plot_ready = 1'b1;
        @(posedge clk);
        #1;
        if (keep_start == 0) start = 1'b0;
        k = 0;
        got = 1'b0;
        while (k < 25000 && !got) begin
            if (k == 1) begin
                x0 = ~x0;
                x1 = ~x1;
                y0 = ~y0;
                y1 = ~y1;
                colour = ~colour;
                mode = ~mode;
            end
            if (vga_plot && acc == stall_idx && stalled < stall_len) begin
                plot_ready = 1'b0;
                stalled++;
            end else begin
                plot_ready = 1'b1;
            end
            if (done) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check({name, "_latency"}, got ? k : -1, exp_lat);
        check({name, "_plots"}, seen_q.size(), n);
        check({name, "_busy_in_done"}, int'(busy), 0);
        check({name, "_plot_in_done"}, int'(vga_plot), 0);
        plot_ready = 1'b1;
        if (keep_start != 0) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                check({name, "_done_held"}, int'(done), 1);
            end
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check({name, "_done_cleared"}, int'(done), 0);
    endtask

    task automatic check_pix(input string name, input int idx, input int ex, input int ey,
                             input int ec);
        if (idx < seen_q.size()) begin
            check({name, "_x"}, seen_q[idx].x, ex);
            check({name, "_y"}, seen_q[idx].y, ey);
            check({name, "_c"}, seen_q[idx].c, ec);
        end else begin
            check({name, "_present"}, seen_q.size(), idx + 1);
        end
    endtask

    initial begin
        int ex[6];
        int ey[6];
        int ec[6];
        int k;
        ex = '{10, 10, 11, 11, 12, 12};
        ey = '{20, 21, 20, 21, 20, 21};
        ec = '{2, 2, 3, 3, 4, 4};
        rst = 1'b1;
        start = 1'b1;
        x0 = '0;
        x1 = '0;
        y0 = '0;
        y1 = '0;
        colour = '0;
        mode = '0;
        plot_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_x", int'(vga_x), 0);
        check("rst_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        rst = 1'b0;
        start = 1'b0;

        do_op("full", 0, 159, 0, 119, 5, 0, -1, 0, 0, 19202);
        check("full_count", seen_q.size(), 19200);
        check_pix("full_first", 0, 0, 0, 5);
        check_pix("full_last", 19199, 159, 119, 5);

        do_op("colstripe", 10, 12, 20, 21, 0, 1, -1, 0, 0, 8);
        for (int i = 0; i < 6; i++) check_pix("colstripe_px", i, ex[i], ey[i], ec[i]);

        do_op("stall", 10, 12, 20, 21, 0, 1, 1, 3, 0, 11);
        check_pix("stall_held_px", 1, 10, 21, 2);
        check("stall_hold_len", (hold_len.size() > 1) ? hold_len[1] : -1, 4);
        check_pix("stall_next_px", 2, 11, 20, 3);

        do_op("empty_x", 5, 4, 0, 3, 2, 0, -1, 0, 1, 1);
        do_op("offscreen_y", 0, 3, 125, 127, 2, 0, -1, 0, 0, 1);
        do_op("offscreen_x", 170, 180, 0, 0, 2, 0, -1, 0, 0, 1);

        do_op("clamp_checker", 158, 200, 0, 0, 1, 3, -1, 0, 0, 4);
        check_pix("clamp_px0", 0, 158, 0, 1);
        check_pix("clamp_px1", 1, 159, 0, 6);

        do_op("rowstripe", 3, 4, 5, 7, 6, 2, 4, 2, 0, 10);
        check_pix("rowstripe_px0", 0, 3, 5, 3);
        check_pix("rowstripe_px5", 5, 4, 7, 5);

        // Abort a full-screen fill after the 50th accepted pixel.
        build_model(0, 159, 0, 119, 5, 0);
        acc = 0;
        @(posedge clk);
        #1;
        x0 = 8'd0;
        x1 = 8'd159;
        y0 = 7'd0;
        y1 = 7'd119;
        colour = 3'd5;
        mode = 2'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (acc < 50 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort_reached_50", acc, 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_plot", int'(vga_plot), 0);
        check("abort_done", int'(done), 0);
        check("abort_busy", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_idle_busy", int'(busy), 0);

        do_op("restart", 0, 1, 0, 1, 3, 0, -1, 0, 0, 6);
        check_pix("restart_px3", 3, 1, 1, 3);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
